// File: rtl/frame_mem_pkg.sv
// Shared definitions for the frame-memory arbiter: FSM state encoding and default sizing.
package frame_mem_pkg;

   localparam int DEF_ADDRESS_WIDTH = 25;
   localparam int DEF_DATA_WIDTH    = 16;
   localparam int DEF_WR_DEPTH      = 4;
   localparam int DEF_STARVE_LIMIT  = 8;
   localparam int DEF_MAX_RD_OUT    = 4;

   // ISSUE_WR owns bit 1 alone so mem_wr reduces to a single flop bit.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ISSUE_RD = 2'b01,
      ISSUE_WR = 2'b10
   } arb_state_t;

endpackage

// File: rtl/wr_cmd_fifo.sv
// Circular write-command buffer with first-word fall-through output and occupancy count.
module wr_cmd_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = storage[rd_ptr];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // NOTE: storage has no reset; an entry is only ever read after a push wrote it, so
   // clearing the array would add reset fan-out without changing behaviour.
   always_ff @(posedge clk_sys) begin
      if (push_ok) storage[wr_ptr] <= push_data;
   end

   // NOTE: all state updates use non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Arbitrates host writes (buffered) and scanout reads onto one memory command port,
// read-first with a starvation guard for writes and a cap on outstanding reads.
module frame_mem_arbiter
   import frame_mem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int WR_DEPTH      = DEF_WR_DEPTH,
   parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT,
   parameter int MAX_RD_OUT    = DEF_MAX_RD_OUT
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   input  logic [ADDRESS_WIDTH-1:0] wr_address,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     wr_ready,
   input  logic                     rd_req,
   input  logic [ADDRESS_WIDTH-1:0] rd_address,
   output logic                     rd_grant,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_data_valid,
   output logic                     mem_cmd_valid,
   output logic                     mem_wr,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_busy,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_rdata_valid,
   output logic                     wr_pending
);

   localparam int ENTRY_W  = ADDRESS_WIDTH + DATA_WIDTH;
   localparam int CNT_W    = $clog2(WR_DEPTH + 1);
   localparam int OUT_W    = $clog2(MAX_RD_OUT + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t          state;
   logic [ENTRY_W-1:0]  fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [OUT_W-1:0]    outstanding;
   logic [STARVE_W-1:0] starve_cnt;
   logic                rd_eligible;
   logic                rd_return;
   logic                issue_rd;
   logic                issue_wr;

   wr_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (WR_DEPTH)
   ) u_wr_cmd_fifo (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (wr_valid & wr_ready),
      .push_data ({wr_address, wr_data}),
      .pop       (issue_wr),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign wr_ready    = ~fifo_full;
   assign wr_pending  = (fifo_count != '0);
   assign rd_eligible = rd_req && (outstanding < OUT_W'(MAX_RD_OUT));
   // Returns with nothing outstanding are stale (e.g. issued before a reset) and dropped.
   assign rd_return   = mem_rdata_valid && (outstanding != '0);
   assign rd_grant    = issue_rd;
   assign mem_wr      = (state == ISSUE_WR);

   // NOTE: both decision outputs get a default before any branch, so no path leaves
   // them unassigned and no latch is inferred.
   always_comb begin
      issue_rd = 1'b0;
      issue_wr = 1'b0;
      if (!mem_busy) begin
         if (!fifo_empty && (starve_cnt == STARVE_W'(STARVE_LIMIT) || !rd_eligible)) begin
            issue_wr = 1'b1;
         end else if (rd_eligible) begin
            issue_rd = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         mem_cmd_valid <= 1'b0;
         mem_address   <= '0;
         mem_wdata     <= '0;
      end else begin
         mem_cmd_valid <= issue_rd | issue_wr;
         if (!mem_busy) begin
            if (issue_wr) begin
               state       <= ISSUE_WR;
               mem_address <= fifo_head[ENTRY_W-1:DATA_WIDTH];
               mem_wdata   <= fifo_head[DATA_WIDTH-1:0];
            end else if (issue_rd) begin
               state       <= ISSUE_RD;
               mem_address <= rd_address;
            end else begin
               state       <= IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
         starve_cnt  <= '0;
      end else begin
         case ({issue_rd, rd_return})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (issue_wr) begin
            starve_cnt <= '0;
         end else if (issue_rd && !fifo_empty && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else begin
         rd_data_valid <= rd_return;
         if (rd_return) rd_data <= mem_rdata;
      end
   end

endmodule
